// File: rtl/mem_access_arbiter_if.sv
// Memory-side handshake bundle for the IF/LS memory arbiter.
// master: the arbiter (drives the request), slave: the memory subsystem.
interface mem_access_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      memReq;
    logic                      memWrite;
    logic [ADDR_WIDTH-1:0]     memAddr;
    logic [DATA_WIDTH-1:0]     memWriteData;
    logic [DATA_WIDTH/8-1:0]   memByteEnable;
    logic                      memAccept;
    logic                      memDone;
    logic [DATA_WIDTH-1:0]     memReadData;

    modport master (
        output memReq, memWrite, memAddr, memWriteData, memByteEnable,
        input  memAccept, memDone, memReadData
    );

    modport slave (
        input  memReq, memWrite, memAddr, memWriteData, memByteEnable,
        output memAccept, memDone, memReadData
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the single memory port between instruction
// fetch (IF) and load/store (LS), one outstanding transaction at a time.
// LS has strict priority. A fetch that sees a flush while in flight still
// completes on the memory side but its completion is swallowed.
// Optional: define MEM_ARB_STARVATION_GUARD_EN to force an IF grant after
// STARVE_LIMIT (1..7) consecutive LS grants while IF was waiting.
module mem_access_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    ifReq,
    input  logic [ADDR_WIDTH-1:0]   ifAddr,
    output logic                    ifGrant,
    output logic                    ifDone,
    output logic [DATA_WIDTH-1:0]   ifReadData,
    input  logic                    lsReq,
    input  logic                    lsWrite,
    input  logic [ADDR_WIDTH-1:0]   lsAddr,
    input  logic [DATA_WIDTH-1:0]   lsWriteData,
    input  logic [DATA_WIDTH/8-1:0] lsByteEnable,
    output logic                    lsGrant,
    output logic                    lsDone,
    output logic [DATA_WIDTH-1:0]   lsReadData,
    mem_access_arbiter_if.master    mem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                  state_q, state_d;
    logic                    own_if_q;   // 1 = IF owns the transaction, 0 = LS
    logic                    discard_q;  // in-flight fetch was flushed
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic                    if_gnt, ls_gnt;
    logic                    force_if;
    logic                    busy;
    logic                    complete;

    assign busy     = (state_q == S_REQ) || (state_q == S_WAIT);
    assign complete = (state_q == S_WAIT) && mem.memDone;

`ifdef MEM_ARB_STARVATION_GUARD_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);
    logic [2:0] starve_cnt_q;

    // Waiting fetch overrides LS priority once it has lost often enough.
    assign force_if = lsReq && ifReq && !flush && (starve_cnt_q >= STARVE_LIM);

    // Count LS grants that a live fetch lost; saturate at 7.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt_q <= '0;
        else if (!ifReq || if_gnt)
            starve_cnt_q <= '0;
        else if (ls_gnt && !flush && starve_cnt_q != 3'd7)
            starve_cnt_q <= starve_cnt_q + 3'd1;
    end
`else
    logic unused_starve_limit;
    assign force_if            = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Arbitration and next state; grants are combinational in IDLE.
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        ls_gnt  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rst) begin
                    if (lsReq && !force_if)
                        ls_gnt = 1'b1;
                    else if (ifReq && !flush)
                        if_gnt = 1'b1;
                end
                if (ls_gnt || if_gnt)
                    state_d = S_REQ;
            end
            S_REQ:   if (mem.memAccept) state_d = S_WAIT;
            S_WAIT:  if (mem.memDone)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ifGrant = if_gnt;
    assign lsGrant = ls_gnt;

    // Latch the winning request's fields on the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            own_if_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else if (ls_gnt) begin
            own_if_q <= 1'b0;
            wr_q     <= lsWrite;
            addr_q   <= lsAddr;
            wdata_q  <= lsWriteData;
            be_q     <= lsByteEnable;
        end else if (if_gnt) begin
            own_if_q <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= ifAddr;
            wdata_q  <= '0;
            be_q     <= '1;
        end
    end

    // Remember a flush that hit an in-flight fetch; cleared at completion.
    always_ff @(posedge clk) begin
        if (rst)
            discard_q <= 1'b0;
        else if (complete)
            discard_q <= 1'b0;
        else if (busy && own_if_q && flush)
            discard_q <= 1'b1;
    end

    // Registered completion pulses; read data holds until the next delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifDone     <= 1'b0;
            lsDone     <= 1'b0;
            ifReadData <= '0;
            lsReadData <= '0;
        end else begin
            ifDone <= 1'b0;
            lsDone <= 1'b0;
            if (complete) begin
                if (!own_if_q) begin
                    lsDone     <= 1'b1;
                    lsReadData <= mem.memReadData;
                end else if (!discard_q && !flush) begin
                    ifDone     <= 1'b1;
                    ifReadData <= mem.memReadData;
                end
            end
        end
    end

    assign mem.memReq        = (state_q == S_REQ);
    assign mem.memWrite      = (state_q == S_REQ) && wr_q;
    assign mem.memAddr       = addr_q;
    assign mem.memWriteData  = wdata_q;
    assign mem.memByteEnable = be_q;

endmodule
